// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI4-Lite SRAM responder.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         CNT_W       = 16;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } wr_state_t;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                r[i*8 +: 8] = wd[i*8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_delay_lfsr.sv
// Response delay counter with optional LFSR jitter.
// Define RAND_DELAY_EN to add 0..15 random cycles per load.
module sram_delay_lfsr
    import axi_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] base_lat,
    output logic             done
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] extra;

`ifdef RAND_DELAY_EN
    logic [15:0] lfsr;
    logic        fb;

    // Fibonacci taps 16,14,13,11
    assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], fb};
        end
    end

    assign extra = {{(CNT_W-4){1'b0}}, lfsr[3:0]};
`else
    logic unused_seed;

    assign unused_seed = ^LFSR_SEED;
    assign extra       = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= base_lat - CNT_W'(1) + extra;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/axi_sram_responder.sv
// AXI4-Lite single-beat responder over a word SRAM array.
// Optional random response delay: define RAND_DELAY_EN.
module axi_sram_responder
    import axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          RD_LAT      = 1,
    parameter int          WR_LAT      = 1,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arvalid,
    input  logic [31:0] araddr,
    output logic        arready,
    output logic        rvalid,
    output logic [1:0]  rresp,
    output logic [31:0] rdata,
    input  logic        rready,
    input  logic        awvalid,
    input  logic [31:0] awaddr,
    output logic        awready,
    input  logic        wvalid,
    input  logic [31:0] wdata,
    input  logic [7:0]  wstrb,
    output logic        wready,
    output logic        bvalid,
    output logic [1:0]  bresp,
    input  logic        bready
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

    function automatic logic hit(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE_ADDR;
        return {1'b0, o} < SPAN;
    endfunction

    function automatic logic [AW-1:0] idx(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    // Read channel state
    rd_state_t   r_state, r_state_d;
    logic        arready_d, rvalid_d;
    logic [1:0]  rresp_d;
    logic [31:0] rdata_d;
    logic [31:0] raddr_q, raddr_d;
    logic        rd_load, rd_done;

    // Write channel state
    wr_state_t   w_state, w_state_d;
    logic        awready_d, wready_d, bvalid_d;
    logic [1:0]  bresp_d;
    logic        aw_got, aw_got_d;
    logic        w_got, w_got_d;
    logic        wr_err, wr_err_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_hs, w_hs;
    logic [31:0] c_addr, c_data;
    logic [3:0]  c_strb;
    logic        commit, wr_load, wr_done;
    logic        unused_strb;

    assign unused_strb = ^wstrb[7:4];

    sram_delay_lfsr #(
        .LFSR_SEED (LFSR_SEED)
    ) u_rd_dly (
        .clk      (clk),
        .rst      (rst),
        .load     (rd_load),
        .base_lat (CNT_W'(RD_LAT)),
        .done     (rd_done)
    );

    sram_delay_lfsr #(
        .LFSR_SEED (LFSR_SEED)
    ) u_wr_dly (
        .clk      (clk),
        .rst      (rst),
        .load     (wr_load),
        .base_lat (CNT_W'(WR_LAT)),
        .done     (wr_done)
    );

    always_comb begin
        r_state_d = r_state;
        arready_d = arready;
        rvalid_d  = rvalid;
        rresp_d   = rresp;
        rdata_d   = rdata;
        raddr_d   = raddr_q;
        rd_load   = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready) begin
                    raddr_d   = araddr;
                    arready_d = 1'b0;
                    rd_load   = 1'b1;
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (rd_done) begin
                    rvalid_d  = 1'b1;
                    r_state_d = R_RESP;
                    if (hit(raddr_q)) begin
                        rdata_d = mem[idx(raddr_q)];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                end
            end
            R_RESP: begin
                if (rready) begin
                    rvalid_d  = 1'b0;
                    rdata_d   = '0;
                    rresp_d   = RESP_OKAY;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rresp   <= RESP_OKAY;
            rdata   <= '0;
            raddr_q <= '0;
        end else begin
            r_state <= r_state_d;
            arready <= arready_d;
            rvalid  <= rvalid_d;
            rresp   <= rresp_d;
            rdata   <= rdata_d;
            raddr_q <= raddr_d;
        end
    end

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    // A channel captured earlier wins over the live bus value
    assign c_addr = aw_got ? awaddr_q : awaddr;
    assign c_data = w_got ? wdata_q : wdata;
    assign c_strb = w_got ? wstrb_q : wstrb[3:0];

    always_comb begin
        w_state_d = w_state;
        awready_d = awready;
        wready_d  = wready;
        bvalid_d  = bvalid;
        bresp_d   = bresp;
        aw_got_d  = aw_got;
        w_got_d   = w_got;
        wr_err_d  = wr_err;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        commit    = 1'b0;
        wr_load   = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_got_d = 1'b1;
                    awaddr_d = awaddr;
                end
                if (w_hs) begin
                    w_got_d = 1'b1;
                    wdata_d = wdata;
                    wstrb_d = wstrb[3:0];
                end
                awready_d = !(aw_got || aw_hs);
                wready_d  = !(w_got || w_hs);
                if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                    commit    = 1'b1;
                    wr_load   = 1'b1;
                    wr_err_d  = !hit(c_addr);
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    w_state_d = W_WAIT;
                end
            end
            W_WAIT: begin
                if (wr_done) begin
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state  <= W_IDLE;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            wr_err   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            w_state  <= w_state_d;
            awready  <= awready_d;
            wready   <= wready_d;
            bvalid   <= bvalid_d;
            bresp    <= bresp_d;
            aw_got   <= aw_got_d;
            w_got    <= w_got_d;
            wr_err   <= wr_err_d;
            awaddr_q <= awaddr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
        end
    end

    // Array is not reset so contents survive a mid-transaction reset
    always_ff @(posedge clk) begin
        if (commit && hit(c_addr)) begin
            mem[idx(c_addr)] <= byte_merge(mem[idx(c_addr)], c_data, c_strb);
        end
    end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Self-checking bench for axi_sram_responder.
// Honours RAND_DELAY_EN for latency expectations.
module tb_axi_sram_responder;

    localparam int RD_LAT = 2;
    localparam int WR_LAT = 3;
`ifdef RAND_DELAY_EN
    localparam int SETTLE = 20;
`else
    localparam int SETTLE = 4;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        arvalid = 1'b0;
    logic [31:0] araddr = '0;
    logic        arready;
    logic        rvalid;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic        rready = 1'b0;
    logic        awvalid = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awready;
    logic        wvalid = 1'b0;
    logic [31:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready = 1'b0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t rq[$];
    exp_t bq[$];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  strb;
        int          aw_at;
        int          w_at;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    localparam int NV = 17;
    vec_t vt[NV];

    axi_sram_responder #(
        .BASE_ADDR   (32'h8000_0000),
        .DEPTH_WORDS (4096),
        .RD_LAT      (RD_LAT),
        .WR_LAT      (WR_LAT),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .arvalid (arvalid),
        .araddr  (araddr),
        .arready (arready),
        .rvalid  (rvalid),
        .rresp   (rresp),
        .rdata   (rdata),
        .rready  (rready),
        .awvalid (awvalid),
        .awaddr  (awaddr),
        .awready (awready),
        .wvalid  (wvalid),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wready  (wready),
        .bvalid  (bvalid),
        .bresp   (bresp),
        .bready  (bready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fail_to(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: timed out, got no response want one", nm);
    endtask

    task automatic chk_lat(input string nm, input int act, input int base);
        tests++;
`ifdef RAND_DELAY_EN
        if (act < base || act > base + 15) begin
            fails++;
            $display("FAIL %s: got %0d want %0d..%0d", nm, act, base, base + 15);
        end
`else
        if (act != base) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", nm, act, base);
        end
`endif
    endtask

    // n = posedges after the handshake edge until valid seen, -1 on timeout
    task automatic wait_valid(input bit is_r, output int n);
        n = 0;
        while (!(is_r ? rvalid : bvalid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!(is_r ? rvalid : bvalid)) n = -1;
    endtask

    task automatic do_read(input string nm, input logic [31:0] a,
                           input exp_t e, output int lat);
        int   n;
        exp_t x;
        lat = -1;
        @(negedge clk);
        arvalid = 1'b1;
        araddr  = a;
        n = 0;
        while (!arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!arready) begin
            fail_to({nm, "_ar"});
            arvalid = 1'b0;
            return;
        end
        rq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        araddr  = '0;
        wait_valid(1'b1, n);
        x = rq.pop_front();
        if (n < 0) begin
            fail_to({nm, "_r"});
            return;
        end
        lat = n;
        chk({nm, "_rdata"}, rdata, x.data);
        chk({nm, "_rresp"}, rresp, x.resp);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk({nm, "_rdone"}, {rvalid, arready, rdata}, {2'b01, 32'h0});
    endtask

    task automatic do_write(input string nm, input logic [31:0] a,
                            input logic [31:0] d, input logic [7:0] s,
                            input int aw_at, input int w_at,
                            input exp_t e, output int lat);
        bit   awd, wd;
        logic hs_aw, hs_w;
        int   n;
        exp_t x;
        lat = -1;
        awd = 1'b0;
        wd  = 1'b0;
        for (int c = 0; c < 60 && !(awd && wd); c++) begin
            @(negedge clk);
            if (awd) awvalid = 1'b0;
            if (wd) wvalid = 1'b0;
            if (c == aw_at) begin
                awvalid = 1'b1;
                awaddr  = a;
            end
            if (c == w_at) begin
                wvalid = 1'b1;
                wdata  = d;
                wstrb  = s;
            end
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge clk);
            if (hs_aw) awd = 1'b1;
            if (hs_w) wd = 1'b1;
        end
        if (!(awd && wd)) begin
            fail_to({nm, "_aw_w"});
            awvalid = 1'b0;
            wvalid  = 1'b0;
            return;
        end
        bq.push_back(e);
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wait_valid(1'b0, n);
        x = bq.pop_front();
        if (n < 0) begin
            fail_to({nm, "_b"});
            return;
        end
        lat = n;
        chk({nm, "_bresp"}, bresp, x.resp);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk({nm, "_bdone"}, {bvalid, awready, wready}, 3'b011);
    endtask

    initial begin
        int   lat;
        int   n;
        int   nd;
        bit   stale;
        bit   seen[64];
        exp_t e;

        vt[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0, 0, 2'b00, 32'h0};
        vt[1]  = '{1'b0, 32'h8000_0010, 32'h0, 8'h0, 0, 0, 2'b00, 32'hDEAD_BEEF};
        vt[2]  = '{1'b1, 32'h8000_0000, 32'h0123_4567, 8'h0F, 0, 0, 2'b00, 32'h0};
        vt[3]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 8'h0F, 0, 0, 2'b00, 32'h0};
        vt[4]  = '{1'b1, 32'h8000_0020, 32'h0000_AB00, 8'h02, 0, 5, 2'b00, 32'h0};
        vt[5]  = '{1'b0, 32'h8000_0020, 32'h0, 8'h0, 0, 0, 2'b00, 32'h1122_AB44};
        vt[6]  = '{1'b0, 32'h7FFF_FFFC, 32'h0, 8'h0, 0, 0, 2'b10, 32'h0};
        vt[7]  = '{1'b1, 32'h8000_4000, 32'hCAFE_F00D, 8'h0F, 0, 0, 2'b10, 32'h0};
        vt[8]  = '{1'b0, 32'h8000_0000, 32'h0, 8'h0, 0, 0, 2'b00, 32'h0123_4567};
        vt[9]  = '{1'b0, 32'h8000_4000, 32'h0, 8'h0, 0, 0, 2'b10, 32'h0};
        vt[10] = '{1'b1, 32'h8000_3FFC, 32'h5A5A_5A5A, 8'h0F, 5, 0, 2'b00, 32'h0};
        vt[11] = '{1'b0, 32'h8000_3FFF, 32'h0, 8'h0, 0, 0, 2'b00, 32'h5A5A_5A5A};
        vt[12] = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 8'h00, 0, 0, 2'b00, 32'h0};
        vt[13] = '{1'b0, 32'h8000_0010, 32'h0, 8'h0, 0, 0, 2'b00, 32'hDEAD_BEEF};
        vt[14] = '{1'b1, 32'h8000_0013, 32'h9900_0000, 8'hF8, 2, 2, 2'b00, 32'h0};
        vt[15] = '{1'b0, 32'h8000_0010, 32'h0, 8'h0, 0, 0, 2'b00, 32'h99AD_BEEF};
        vt[16] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 8'h0, 0, 0, 2'b10, 32'h0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outs", {arready, rvalid, rresp, rdata, awready, wready, bvalid, bresp}, 64'h0);
        rst = 1'b1;
        #1;
        chk("rel_pre_edge", {arready, awready, wready}, 3'b000);
        @(negedge clk);
        chk("rel_readies", {arready, awready, wready, rvalid, bvalid}, 5'b11100);

        for (int i = 0; i < NV; i++) begin
            e.data = vt[i].rdata;
            e.resp = vt[i].resp;
            if (vt[i].wr) begin
                do_write($sformatf("v%0d", i), vt[i].addr, vt[i].data, vt[i].strb,
                         vt[i].aw_at, vt[i].w_at, e, lat);
                if (lat >= 0) chk_lat($sformatf("v%0d_wlat", i), lat, WR_LAT);
            end else begin
                do_read($sformatf("v%0d", i), vt[i].addr, e, lat);
                if (lat >= 0) chk_lat($sformatf("v%0d_rlat", i), lat, RD_LAT);
            end
        end

        // Backpressure: hold rready/bready low for 10 cycles
        @(negedge clk);
        arvalid = 1'b1;
        araddr  = 32'h8000_0010;
        awvalid = 1'b1;
        awaddr  = 32'h8000_0024;
        wvalid  = 1'b1;
        wdata   = 32'h7777_7777;
        wstrb   = 8'h0F;
        chk("bp_ready_in", {arready, awready, wready}, 3'b111);
        @(negedge clk);
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        repeat (SETTLE) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bp_hold%0d", k),
                {rvalid, bvalid, arready, awready, wready, rresp, bresp}, 9'h180);
            chk($sformatf("bp_data%0d", k), rdata, 32'h99AD_BEEF);
            @(negedge clk);
        end
        rready = 1'b1;
        bready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        bready = 1'b0;
        chk("bp_release", {rvalid, bvalid, arready, awready, wready}, 5'b00111);
        chk("bp_rdata_clr", rdata, 32'h0);
        e.data = 32'h7777_7777;
        e.resp = 2'b00;
        do_read("bp_rb", 32'h8000_0024, e, lat);

`ifndef RAND_DELAY_EN
        // Write commit on the same edge as read sample returns old data
        @(negedge clk);
        arvalid = 1'b1;
        araddr  = 32'h8000_0020;
        @(negedge clk);
        arvalid = 1'b0;
        repeat (RD_LAT - 1) @(negedge clk);
        awvalid = 1'b1;
        awaddr  = 32'h8000_0020;
        wvalid  = 1'b1;
        wdata   = 32'hFFFF_0000;
        wstrb   = 8'h0F;
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wait_valid(1'b1, n);
        if (n < 0) begin
            fail_to("coll_r");
        end else begin
            chk("coll_old", rdata, 32'h1122_AB44);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        wait_valid(1'b0, n);
        if (n < 0) begin
            fail_to("coll_b");
        end else begin
            chk("coll_bresp", bresp, 2'b00);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        e.data = 32'hFFFF_0000;
        e.resp = 2'b00;
        do_read("coll_new", 32'h8000_0020, e, lat);
`endif

        // Reset while both FSMs are waiting
        @(negedge clk);
        arvalid = 1'b1;
        araddr  = 32'h8000_0010;
        awvalid = 1'b1;
        awaddr  = 32'h8000_0030;
        wvalid  = 1'b1;
        wdata   = 32'h0000_0001;
        wstrb   = 8'h0F;
        @(negedge clk);
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_outs", {arready, rvalid, rresp, rdata, awready, wready, bvalid, bresp}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rel_readies", {arready, awready, wready, rvalid, bvalid}, 5'b11100);
        stale = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (rvalid || bvalid) stale = 1'b1;
        end
        chk("no_stale", stale, 1'b0);
        e.data = 32'h99AD_BEEF;
        e.resp = 2'b00;
        do_read("retained", 32'h8000_0010, e, lat);

`ifdef RAND_DELAY_EN
        for (int k = 0; k < 64; k++) seen[k] = 1'b0;
        for (int k = 0; k < 100; k++) begin
            do_read($sformatf("rnd%0d", k), 32'h8000_0010, e, lat);
            if (lat >= 0) begin
                chk_lat($sformatf("rnd%0d_lat", k), lat, RD_LAT);
                if (lat < 64) seen[lat] = 1'b1;
            end
        end
        nd = 0;
        for (int k = 0; k < 64; k++) nd += int'(seen[k]);
        chk("rnd_distinct_gt1", nd > 1, 1'b1);
`else
        nd = 0;
        for (int k = 0; k < 64; k++) seen[k] = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
